// File: rtl/adder_tree_accum.sv
// Sparse-masked, pipelined adder tree feeding a plain or MSB-first shift-add accumulator.
// Emits one result per ACC_LEN accepted beats with a single-cycle valid strobe.
module adder_tree_accum #(
  parameter  int unsigned N_IN     = 4,
  parameter  int unsigned IN_W     = 4,
  parameter  int unsigned ACC_LEN  = 4,
  localparam int unsigned TREE_LAT = (N_IN > 1) ? $clog2(N_IN) : 0,
  localparam int unsigned SUM_W    = IN_W + TREE_LAT,
  localparam int unsigned OUT_W    = SUM_W + ACC_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic [N_IN-1:0]      in_mask,
  input  logic                 shift_mode,
  output logic [OUT_W-1:0]     op,
  output logic                 op_valid,
  output logic                 busy
);

  localparam int unsigned NPAD      = 1 << TREE_LAT;
  localparam int unsigned TREE_BITS = (2 * NPAD - 1) * SUM_W;
  localparam int unsigned CNT_W     = $clog2(ACC_LEN);

  // Node offset (in SUM_W units) of the first entry of tree level s in r_tree.
  function automatic int unsigned lvl_off(input int unsigned s);
    return 2 * NPAD - 2 * (NPAD >> s);
  endfunction

  logic [NPAD*SUM_W-1:0] w_lanes;
  logic [TREE_BITS-1:0]  r_tree;
  logic [SUM_W-1:0]      w_tree_sum;

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_last;
  logic                  w_beat_mode;
  logic                  r_grp_mode;
  logic                  w_last_pend;
  logic [TREE_LAT:0]     r_vld;
  logic [TREE_LAT:0]     r_last;
  logic [TREE_LAT:0]     r_mode;

  logic [OUT_W-1:0]      r_acc;
  logic [OUT_W-1:0]      w_acc_nxt;
  logic [OUT_W-1:0]      r_op;
  logic                  r_op_valid;
  logic                  r_busy;

  // Masked lanes, zero-padded up to the next power of two.
  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (in_mask[i]) w_lanes[i*SUM_W +: SUM_W] = SUM_W'(in_data[i*IN_W +: IN_W]);
    end
  end

  // Level 0 registers the lanes; each further level registers pairwise sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tree <= '0;
    end else begin
      r_tree[0 +: NPAD*SUM_W] <= w_lanes;
      for (int s = 1; s <= int'(TREE_LAT); s++) begin
        for (int j = 0; j < int'(NPAD >> s); j++) begin
          r_tree[(int'(lvl_off(s)) + j) * SUM_W +: SUM_W] <=
            r_tree[(int'(lvl_off(s - 1)) + 2 * j) * SUM_W +: SUM_W] +
            r_tree[(int'(lvl_off(s - 1)) + 2 * j + 1) * SUM_W +: SUM_W];
        end
      end
    end
  end

  assign w_tree_sum = r_tree[TREE_BITS-1 -: SUM_W];

  assign w_last      = (r_cnt == CNT_W'(ACC_LEN - 1));
  assign w_beat_mode = (r_cnt == '0) ? shift_mode : r_grp_mode;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (in_valid) w_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
  end

  // A group is still outstanding if a last-beat marker will remain in the pipe after this edge.
  always_comb begin
    w_last_pend = in_valid & w_last;
    for (int i = 0; i < int'(TREE_LAT); i++) w_last_pend = w_last_pend | r_last[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_grp_mode <= 1'b0;
      r_vld      <= '0;
      r_last     <= '0;
      r_mode     <= '0;
      r_busy     <= 1'b0;
    end else begin
      for (int i = int'(TREE_LAT); i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
        r_mode[i] <= r_mode[i-1];
      end
      r_vld[0]  <= in_valid;
      r_last[0] <= in_valid & w_last;
      r_mode[0] <= w_beat_mode;
      r_cnt     <= w_cnt_nxt;
      if (in_valid && (r_cnt == '0)) r_grp_mode <= shift_mode;
      r_busy    <= (w_cnt_nxt != '0) | w_last_pend;
    end
  end

  assign w_acc_nxt = r_mode[TREE_LAT] ? ({r_acc[OUT_W-2:0], 1'b0} + OUT_W'(w_tree_sum))
                                      : (r_acc + OUT_W'(w_tree_sum));

  // Accumulate tree outputs; the group's final beat publishes the result and clears the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_op       <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      if (r_vld[TREE_LAT]) begin
        if (r_last[TREE_LAT]) begin
          r_op       <= w_acc_nxt;
          r_op_valid <= 1'b1;
          r_acc      <= '0;
        end else begin
          r_acc <= w_acc_nxt;
        end
      end
    end
  end

  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum (N_IN=4, IN_W=4, ACC_LEN=4): latency, masking, modes, gaps, reset.
module tb_adder_tree_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_mask;
  logic        shift_mode;
  logic [9:0]  op;
  logic        op_valid;
  logic        busy;

  int errors;
  int checks;

  adder_tree_accum #(.N_IN(4), .IN_W(4), .ACC_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .shift_mode (shift_mode),
    .op         (op),
    .op_valid   (op_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then check op_valid/busy after the next rising edge.
  task automatic step(input logic [15:0] d, input logic [3:0] m, input logic v, input logic sm,
                      input logic ev, input logic eb, input string tag);
    in_data    = d;
    in_mask    = m;
    in_valid   = v;
    shift_mode = sm;
    @(negedge clk);
    chk({tag, ".op_valid"}, 32'(op_valid), 32'(ev));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic idle(input logic ev, input logic eb, input string tag);
    step(16'h0000, 4'h0, 1'b0, 1'b0, ev, eb, tag);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_mask    = '0;
    shift_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.op", 32'(op), 32'd0);
    chk("reset.op_valid", 32'(op_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(1'b0, 1'b0, "post_reset");

    // Plain full sum: 4 x 60 = 240, valid three edges after the last beat.
    for (int k = 0; k < 4; k++) step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "full.beat");
    idle(1'b0, 1'b1, "full.lat1");
    idle(1'b0, 1'b1, "full.lat2");
    idle(1'b1, 1'b0, "full.lat3");
    chk("full.op", 32'(op), 32'd240);
    idle(1'b0, 1'b0, "full.after");
    chk("full.op_hold", 32'(op), 32'd240);

    // Sparse mask 0101 on lanes {15,7,3,1}: 18 per beat.
    for (int k = 0; k < 4; k++) step(16'h137F, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, "sparse.beat");
    chk("sparse.op_hold_mid", 32'(op), 32'd240);
    idle(1'b0, 1'b1, "sparse.lat1");
    idle(1'b0, 1'b1, "sparse.lat2");
    idle(1'b1, 1'b0, "sparse.lat3");
    chk("sparse.op", 32'(op), 32'd72);

    // All-zero mask still counts beats and pulses op_valid with 0.
    for (int k = 0; k < 4; k++) step(16'hFFFF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, "zero.beat");
    idle(1'b0, 1'b1, "zero.lat1");
    idle(1'b0, 1'b1, "zero.lat2");
    idle(1'b1, 1'b0, "zero.lat3");
    chk("zero.op", 32'(op), 32'd0);

    // Shift mode, sums 4,0,4,4 -> 44.
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "shift.b0");
    step(16'h1111, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, "shift.b1");
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "shift.b2");
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "shift.b3");
    idle(1'b0, 1'b1, "shift.lat1");
    idle(1'b0, 1'b1, "shift.lat2");
    idle(1'b1, 1'b0, "shift.lat3");
    chk("shift.op", 32'(op), 32'd44);

    // Gapped plain full sum: busy holds through idle cycles.
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "gap.b0");
    idle(1'b0, 1'b1, "gap.i0");
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "gap.b1");
    idle(1'b0, 1'b1, "gap.i1");
    idle(1'b0, 1'b1, "gap.i1");
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "gap.b2");
    for (int k = 0; k < 3; k++) idle(1'b0, 1'b1, "gap.i2");
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "gap.b3");
    idle(1'b0, 1'b1, "gap.lat1");
    idle(1'b0, 1'b1, "gap.lat2");
    idle(1'b1, 1'b0, "gap.lat3");
    chk("gap.op", 32'(op), 32'd240);
    idle(1'b0, 1'b0, "gap.after");

    // shift_mode toggled after beat 0 is ignored: still 44 (plain would give 12).
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "toggle.b0");
    step(16'h1111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, "toggle.b1");
    step(16'h1111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "toggle.b2");
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "toggle.b3");
    idle(1'b0, 1'b1, "toggle.lat1");
    idle(1'b0, 1'b1, "toggle.lat2");
    idle(1'b1, 1'b0, "toggle.lat3");
    chk("toggle.op", 32'(op), 32'd44);

    // Back-to-back: plain 240 then shift 4*(8+4+2+1)=60, pulses 4 cycles apart.
    for (int k = 0; k < 4; k++) step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "b2b.a");
    step(16'h1111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, "b2b.b0");
    step(16'h1111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "b2b.b1");
    step(16'h1111, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, "b2b.b2");
    chk("b2b.op_a", 32'(op), 32'd240);
    step(16'h1111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "b2b.b3");
    idle(1'b0, 1'b1, "b2b.lat1");
    idle(1'b0, 1'b1, "b2b.lat2");
    idle(1'b1, 1'b0, "b2b.lat3");
    chk("b2b.op_b", 32'(op), 32'd60);
    idle(1'b0, 1'b0, "b2b.after");

    // Reset mid-group discards the partial group.
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "rstmid.b0");
    step(16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "rstmid.b1");
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rstmid.op", 32'(op), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.op_valid", 32'(op_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step(16'h1111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, "rstmid.new");
    idle(1'b0, 1'b1, "rstmid.lat1");
    idle(1'b0, 1'b1, "rstmid.lat2");
    idle(1'b1, 1'b0, "rstmid.lat3");
    chk("rstmid.op_new", 32'(op), 32'd16);
    idle(1'b0, 1'b0, "rstmid.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
